// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 64-bit multiply/divide unit for RV64M MUL, DIV, DIVU,
// REM and REMU. It runs one iteration per cycle (64 cycles), or takes a
// one-cycle fast path for divide-by-zero, signed overflow and unsupported ops.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     request a new operation; sampled only in IDLE/DONE
//   op[2:0]   funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b      operands, latched when start is accepted
//   busy      high while iterating (CALC)
//   done      one-cycle pulse; result is valid in that cycle
//   result    last completed result, held until the next done
//   state_dbg current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: start is a request that is taken on any rising edge where
// busy=0 and reset=0. Nothing back-pressures done, and the consumer must take
// result in the done cycle. A start while busy=1 is dropped, not queued.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      state_dbg
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;      // negate quotient at the end
    logic            neg_r;      // negate remainder at the end
    logic [XLEN-1:0] acc;        // MUL accumulator
    logic [XLEN-1:0] mcand;      // MUL multiplicand, shifted left each step
    logic [XLEN-1:0] mplier;     // MUL multiplier, shifted right each step
    logic [XLEN-1:0] rem;        // partial remainder
    logic [XLEN-1:0] quot;       // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0] divisor;

    // ---------------- accept-time decode ----------------
    logic            is_mul, is_div_op, is_signed, is_rem, unsupported;
    logic            b_zero, ovf, fast;
    logic [XLEN-1:0] fast_val, a_mag, b_mag;

    always_comb begin
        is_mul      = (op == 3'b000);
        is_div_op   = op[2];
        is_signed   = op[2] & ~op[0];
        is_rem      = op[1];
        unsupported = ~is_mul & ~is_div_op;
        b_zero      = (b == '0);
        ovf         = is_signed & (a == MIN_NEG) & (b == ALL_ONES);
        fast        = unsupported | (is_div_op & b_zero) | ovf;

        fast_val = '0;
        if (is_div_op && b_zero)
            fast_val = is_rem ? a : ALL_ONES;
        else if (ovf)
            fast_val = is_rem ? '0 : MIN_NEG;

        // Signed ops run the unsigned divider on magnitudes.
        a_mag = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
        b_mag = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    end

    // ---------------- one iteration, combinational ----------------
    logic [XLEN-1:0] acc_nxt, rem_nxt, quot_nxt, q_fin, r_fin, calc_res;
    logic [XLEN:0]   shifted, diff;
    logic            take;

    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);

        // Restoring step: the shifted-in remainder can reach 65 bits, so the
        // trial subtraction carries a guard bit whose MSB flags "went negative".
        shifted  = {rem, quot[XLEN-1]};
        diff     = shifted - {1'b0, divisor};
        take     = ~diff[XLEN];
        rem_nxt  = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quot_nxt = {quot[XLEN-2:0], take};

        q_fin = neg_q ? (~quot_nxt + 1'b1) : quot_nxt;
        r_fin = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;

        case (op_q)
            3'b000:         calc_res = acc_nxt;
            3'b100, 3'b101: calc_res = q_fin;
            3'b110, 3'b111: calc_res = r_fin;
            default:        calc_res = '0;
        endcase
    end

    // ---------------- state and datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            rem     <= '0;
            quot    <= '0;
            divisor <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_q   <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r   <= is_signed & a[XLEN-1];
                        acc     <= '0;
                        mcand   <= a;
                        mplier  <= b;
                        rem     <= '0;
                        quot    <= a_mag;
                        divisor <= b_mag;
                        cnt     <= '0;
                        if (fast) begin
                            result <= fast_val;
                            state  <= S_DONE;
                        end else begin
                            state  <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    rem    <= rem_nxt;
                    quot   <= quot_nxt;
                    cnt    <= cnt + CW'(1);
                    // The last iteration's values go straight into result, so
                    // sign fix-up costs no extra cycle.
                    if (cnt == CW'(XLEN - 1)) begin
                        result <= calc_res;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state == S_CALC);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];

    localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_fast(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        if (!(o == 3'b000 || o[2])) return 1'b1;
        if (o[2] && y == 64'd0) return 1'b1;
        if ((o == 3'b100 || o == 3'b110) && x == MIN_NEG && y == ALL_ONES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [63:0] sx, sy;
        sx = x;
        sy = y;
        case (o)
            3'b000: return x * y;
            3'b101: return (y == 0) ? ALL_ONES : x / y;
            3'b111: return (y == 0) ? x : x % y;
            3'b100: begin
                if (y == 0) return ALL_ONES;
                if (x == MIN_NEG && y == ALL_ONES) return MIN_NEG;
                return sx / sy;
            end
            3'b110: begin
                if (y == 0) return x;
                if (x == MIN_NEG && y == ALL_ONES) return 64'd0;
                return sx % sy;
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    // Called #1 after an edge. Drives start for one cycle, then follows the
    // operation until done, scrambling a/b/op and optionally poking start
    // during CALC (poke = cycle index after accept, 0 = none). Returns in the
    // done cycle so the caller may chain another op back-to-back.
    task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                          input string tag, input int poke);
        int          lat;
        int          bcnt;
        int          exp_lat;
        bit          got;
        logic [63:0] e;
        exp_q.push_back(ref_model(o, x, y));
        exp_lat = is_fast(o, x, y) ? 1 : 65;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        op = 3'($urandom_range(0, 7)); a = rand64(); b = rand64();
        lat = 1; bcnt = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            start = (poke != 0 && lat == poke);
            if (start) begin
                op = 3'b000; a = rand64(); b = rand64();
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
        e = exp_q.pop_front();
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_busy_cycles"}, 64'(bcnt), (exp_lat == 1) ? 64'd0 : 64'd64);
            check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
            check({tag, "_result"}, result, e);
        end
    endtask

    // Idle cycles after a done: done must drop and result must hold.
    task automatic gap(input int n);
        logic [63:0] held;
        held = result;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("gap_done_low", 64'(done), 64'd0);
            check("gap_busy_low", 64'(busy), 64'd0);
        end
        check("gap_result_held", result, held);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          seen;
        logic [2:0]  ro;
        logic [63:0] rx, ry;
        reset = 1'b1; start = 1'b0; op = 3'b000; a = 64'd0; b = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_state", 64'(state_dbg), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy), 64'd0);

        // Directed cases.
        run_op(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, "mul_neg", 0);
        gap(2);
        run_op(3'b101, 64'd100, 64'd7, "divu", 10);
        run_op(3'b111, 64'd100, 64'd7, "remu_b2b", 0);
        gap(2);
        run_op(3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div_neg", 0);
        gap(1);
        run_op(3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem_neg", 0);
        gap(1);
        run_op(3'b101, 64'd5, 64'd0, "divu_by0", 0);
        gap(1);
        run_op(3'b111, 64'd5, 64'd0, "remu_by0", 0);
        run_op(3'b100, MIN_NEG, ALL_ONES, "div_ovf", 0);
        run_op(3'b110, MIN_NEG, ALL_ONES, "rem_ovf", 0);
        run_op(3'b010, 64'd9, 64'd3, "unsupported", 0);
        gap(2);

        // Abort a MUL on iteration 30; a start poke during CALC is ignored.
        start = 1'b1; op = 3'b000; a = rand64(); b = rand64();
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            start = (k == 5);
            if (start) begin
                a = rand64(); b = rand64();
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        run_op(3'b000, 64'd3, 64'd4, "mul_after_abort", 0);
        gap(1);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = 3'b000; a = 64'd3; b = 64'd4;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        check("rst_start_busy2", 64'(busy), 64'd0);
        check("rst_start_done2", 64'(done), 64'd0);

        // Randomized operations, mixed operand classes, random gaps.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ro = 3'b000;
                3:       ro = 3'b100;
                4:       ro = 3'b101;
                5:       ro = 3'b110;
                6:       ro = 3'b111;
                7:       ro = 3'($urandom_range(1, 3));
                default: ro = {1'b1, 2'($urandom_range(0, 3))};
            endcase
            case ($urandom_range(0, 5))
                0: begin rx = rand64(); ry = rand64(); end
                1: begin
                    rx = 64'($urandom_range(0, 100000));
                    ry = 64'($urandom_range(1, 50));
                    if ($urandom_range(0, 1) == 1) rx = ~rx + 64'd1;
                    if ($urandom_range(0, 1) == 1) ry = ~ry + 64'd1;
                end
                2: begin rx = rand64(); ry = 64'd0; end
                3: begin rx = MIN_NEG; ry = ALL_ONES; end
                4: begin rx = rand64(); ry = 64'($urandom_range(1, 1000)); end
                default: begin rx = 64'($urandom_range(0, 1000)); ry = rand64(); end
            endcase
            run_op(ro, rx, ry, "rand", ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : 0);
            if ($urandom_range(0, 2) != 0) gap(int'($urandom_range(1, 3)));
        end
        gap(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 64-bit multiply/divide unit implementing the RV64M MUL, DIV, DIVU, REM and REMU operations. It sits in the execute stage next to the ALU. Its `result` drives the `b` input of the 64-bit 2:1 result-select mux, and that mux's select is asserted while a muldiv instruction writes back. The pipeline holds (stalls) on `busy` and consumes `result` on the cycle `done` is high.

## Interface
- `XLEN`, default 64: operand/result width. Only 64 is supported.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request a new operation. Sampled only when not busy.
- `op` input 3: funct3 encoding.
  - 000 MUL
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
  - 001/010/011 unsupported
- `a` input 64: multiplicand / dividend. Latched on accept.
- `b` input 64: multiplier / divisor. Latched on accept.
- `busy` output 1: iteration in progress. `start` is ignored while high.
- `done` output 1: one-cycle pulse. `result` is valid in that cycle.
- `result` output 64: last completed result. Held until the next `done`.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE with `start`=1: latch `op`, `a`, `b`.
    - Fast-path case: go to DONE.
    - Otherwise: go to CALC with iteration counter = 0.
  - IDLE/DONE with `start`=0: go to IDLE.
  - CALC: one iteration per cycle. Counter 0..63. After counter = 63, go to DONE.
- Outputs by state:
  - `busy` = 1 only in CALC.
  - `done` = 1 only in DONE.
  - Accepting `start` in DONE is legal, which allows back-to-back operations.
- MUL: shift-add over 64 iterations using a 64-bit accumulator. `result` = low 64 bits of a*b. Low bits are sign-agnostic, so no sign handling is needed.
- DIVU/REMU: restoring division with a 64-bit partial remainder plus one guard bit and a 64-bit quotient register. Each iteration shifts one dividend bit in.
- DIV/REM:
  - On accept, operands are converted to magnitudes and the signs are recorded.
  - The unsigned divider then runs as for DIVU/REMU.
  - On entering DONE: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Fast paths (no CALC, `done` one cycle after accept):
  - b = 0: DIV/DIVU `result` = all ones; REM/REMU `result` = a.
  - DIV/REM with a = 0x8000_0000_0000_0000 and b = all ones: DIV `result` = 0x8000_0000_0000_0000; REM `result` = 0.
  - Unsupported op: `result` = 0.
- `result` is written only on entry to DONE. In all other cycles it holds its previous value.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, internal registers 0.
- Reset mid-operation:
  - Aborts the operation. `busy` and `done` are 0 in the cycle after the reset edge.
  - No `done` is issued for the aborted operation.
  - `result` = 0.
- Reset and `start` asserted in the same cycle: reset wins and `start` is dropped.

## Timing
- Edge E0 is the edge that samples `start`=1 in IDLE/DONE.
- Iterative ops:
  - `busy` is high from the cycle after E0 for 64 cycles.
  - `done` is high in the cycle after edge E0+64.
  - Total latency: 65 cycles from accept to `done`.
- Fast-path ops: `done` is high in the cycle after E0. Latency is 1 cycle and `busy` never rises.
- `done` is always exactly one cycle wide.
- `a`, `b`, `op` may change freely after E0; the latched copies are used.
- `start` while `busy` = 1 has no effect. It is not queued.

## Test plan
- MUL, a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> `result` = 0xFFFF_FFFF_FFFF_FFEB (-21). `done` exactly 65 cycles after accept. `busy` high for 64 cycles.
- DIVU, a=100, b=7 -> 14. Back-to-back REMU accepted in the DONE cycle with the same operands -> 2. Each result completes with 65-cycle latency.
- DIV, a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3). REM with the same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- Divide by zero, a=5, b=0:
  - DIVU -> 0xFFFF_FFFF_FFFF_FFFF, `done` 1 cycle after accept, `busy` never high.
  - REMU -> 5.
- Overflow, a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF:
  - DIV -> 0x8000_0000_0000_0000.
  - REM -> 0.
  - Both with 1-cycle latency.
- Start a MUL, pulse `start` with different operands during CALC (ignored), then assert `reset` on iteration 30:
  - `busy`=0, `done`=0, `result`=0 after the reset edge.
  - No `done` pulse follows.
  - A fresh MUL 3*4 afterwards -> 12.
